io_kbd: RTL and testbench

IO_KBD -- requirements
Module: io_kbd

---
 rtl/io_kbd.sv | 90 +++++++++
 tb/tb_io_kbd.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/io_kbd.sv
// Keyboard byte FIFO behind a CPU IO port: status and data reads are combinational onto bus_out.
// The pop or overflow clear lands on the edge after the read strobe ends. Pushes into a full FIFO are dropped and flagged.
module io_kbd #(
   parameter logic [7:0]  DEV_ADDR = 8'h01,
   parameter int unsigned DEPTH    = 4
) (
   input  logic                    CLK,
   input  logic                    reset_n,
   input  logic [7:0]              key_data,
   input  logic                    key_strobe,
   input  logic [7:0]              bus_in,
   input  logic                    io_s,
   input  logic                    io_e,
   input  logic                    io_da,
   input  logic                    io_io,
   output logic [7:0]              bus_out,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [7:0]    dev_sel_q, dev_sel_d;
   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          rd_data_q, rd_stat_q, run_q;
   logic          sel, rd_data, rd_stat, full, empty, pop, push, drop;

   assign sel     = (dev_sel_q == DEV_ADDR);
   assign rd_stat = sel & io_e & io_da & ~io_io;
   assign rd_data = sel & io_e & ~io_da & ~io_io;
   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);

   always_comb begin
      bus_out = 8'h00;
      if (rd_stat)
         bus_out = {5'b0, full, ovf_q, ~empty};
      else if (rd_data && !empty)
         bus_out = mem[head_q];
   end

   // run_q keeps the first edge after reset release from completing a push or pop
   always_comb begin
      pop       = run_q & rd_data_q & ~rd_data & ~empty;
      push      = run_q & key_strobe & (~full | pop);
      drop      = run_q & key_strobe & full & ~pop;
      dev_sel_d = (io_s & io_da & io_io) ? bus_in : dev_sel_q;
      head_d    = pop  ? head_q + 1'b1 : head_q;
      tail_d    = push ? tail_q + 1'b1 : tail_q;
      count_d   = count_q + CW'(push) - CW'(pop);
      ovf_d     = ovf_q;
      if (drop)
         ovf_d = 1'b1;
      else if (run_q & rd_stat_q & ~rd_stat)
         ovf_d = 1'b0;
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         dev_sel_q <= 8'h00;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         rd_data_q <= 1'b0;
         rd_stat_q <= 1'b0;
         run_q     <= 1'b0;
      end else begin
         dev_sel_q <= dev_sel_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         rd_data_q <= rd_data;
         rd_stat_q <= rd_stat;
         run_q     <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (push)
         mem[tail_q] <= key_data;
   end

   assign count    = count_q;
   assign overflow = ovf_q;
endmodule

// File: tb/tb_io_kbd.sv
// Randomized and directed bench for io_kbd against a queue-based model of the IO port.
module tb_io_kbd;
   localparam logic [7:0] DEV   = 8'h01;
   localparam int         DEPTH = 4;

   logic       CLK = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] key_data = 8'h00, bus_in = 8'h00, bus_out;
   logic       key_strobe = 1'b0, io_s = 1'b0, io_e = 1'b0, io_da = 1'b0, io_io = 1'b0;
   logic       overflow;
   logic [2:0] count;

   int checks = 0;
   int failures = 0;

   byte unsigned q[$];
   logic       m_ovf = 1'b0, m_pd = 1'b0, m_ps = 1'b0;
   logic [7:0] m_sel = 8'h00;
   logic [7:0] last_bus;

   always #5 CLK = ~CLK;

   io_kbd #(.DEV_ADDR(DEV), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .reset_n(reset_n), .key_data(key_data), .key_strobe(key_strobe),
      .bus_in(bus_in), .io_s(io_s), .io_e(io_e), .io_da(io_da), .io_io(io_io),
      .bus_out(bus_out), .count(count), .overflow(overflow)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] model_bus(input logic e, input logic da, input logic io);
      logic sel;
      sel = (m_sel == DEV);
      if (sel && e && da && !io)
         return {5'b0, (q.size() == DEPTH), m_ovf, (q.size() != 0)};
      if (sel && e && !da && !io)
         return (q.size() != 0) ? q[0] : 8'h00;
      return 8'h00;
   endfunction

   // One clock cycle; entered and left 1 time unit after a rising edge.
   task automatic step(input logic ks, input logic [7:0] kd, input logic [7:0] bi,
                       input logic s, input logic e, input logic da, input logic io);
      bit cd, cs, dend, send, pop, wasfull;
      key_strobe = ks; key_data = kd; bus_in = bi;
      io_s = s; io_e = e; io_da = da; io_io = io;
      #1;
      last_bus = bus_out;
      chk("bus_out", bus_out, model_bus(e, da, io));
      @(posedge CLK);
      cd      = (m_sel == DEV) && e && !da && !io;
      cs      = (m_sel == DEV) && e && da && !io;
      dend    = m_pd && !cd;
      send    = m_ps && !cs;
      wasfull = (q.size() == DEPTH);
      pop     = dend && (q.size() != 0);
      if (pop) void'(q.pop_front());
      if (ks && (!wasfull || pop)) q.push_back(kd);
      if (ks && wasfull && !pop) m_ovf = 1'b1;
      else if (send) m_ovf = 1'b0;
      if (s && da && io) m_sel = bi;
      m_pd = cd;
      m_ps = cs;
      #1;
      chk("count", count, q.size());
      chk("overflow", overflow, m_ovf);
   endtask

   task automatic idle();
      step(0, 8'h00, 8'h00, 0, 0, 0, 0);
   endtask
   task automatic selw(input logic [7:0] a);
      step(0, 8'h00, a, 1, 0, 1, 1);
   endtask
   task automatic push(input logic [7:0] b);
      step(1, b, 8'h00, 0, 0, 0, 0);
   endtask
   task automatic rdd();
      step(0, 8'h00, 8'h00, 0, 1, 0, 0);
   endtask
   task automatic rds();
      step(0, 8'h00, 8'h00, 0, 1, 1, 0);
   endtask
   task automatic read_byte(input string tag, input logic [7:0] exp);
      rdd();
      chk(tag, last_bus, exp);
      idle();
   endtask

   // Entered 1 unit after a rising edge with whatever inputs are currently applied.
   task automatic do_reset();
      #2 reset_n = 1'b0;
      #1;
      chk("rst_count", count, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_bus", bus_out, 0);
      q.delete(); m_ovf = 1'b0; m_pd = 1'b0; m_ps = 1'b0; m_sel = 8'h00;
      key_strobe = 0; io_s = 0; io_e = 0; io_da = 0; io_io = 0;
      @(posedge CLK);
      #1 reset_n = 1'b1;
      idle();
   endtask

   logic       r_ks, r_s, r_e, r_da, r_io;
   logic [7:0] r_kd, r_bi;

   initial begin
      @(posedge CLK);
      #1;
      chk("init_count", count, 0);
      chk("init_ovf", overflow, 0);
      chk("init_bus", bus_out, 0);
      reset_n = 1'b1;
      idle();

      // select, then a held data read
      selw(DEV);
      push(8'h41);
      for (int i = 0; i < 3; i++) begin
         rdd();
         chk("held_read_bus", last_bus, 8'h41);
      end
      chk("held_read_cnt_before", count, 1);
      idle();
      chk("held_read_cnt_after", count, 0);

      // ordering across pointer wrap
      for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
      for (int i = 0; i < 2; i++) read_byte("wrap_order", 8'h10 + 8'(i));
      push(8'h14);
      push(8'h15);
      for (int i = 0; i < 4; i++) read_byte("wrap_order", 8'h12 + 8'(i));
      chk("wrap_end_cnt", count, 0);

      // overflow and status clear
      for (int i = 0; i < 5; i++) push(8'h20 + 8'(i));
      chk("ovf_cnt", count, 4);
      chk("ovf_flag", overflow, 1);
      rds();
      chk("status_full_ovf", last_bus, 8'h07);
      idle();
      rds();
      chk("status_cleared", last_bus, 8'h05);
      idle();
      for (int i = 0; i < 4; i++) read_byte("ovf_drain", 8'h20 + 8'(i));

      // push coinciding with the pop edge, full then empty
      for (int i = 0; i < 4; i++) push(8'h30 + 8'(i));
      rdd();
      step(1, 8'h55, 8'h00, 0, 0, 0, 0);
      chk("simul_full_cnt", count, 4);
      chk("simul_full_ovf", overflow, 0);
      for (int i = 1; i < 4; i++) read_byte("simul_drain", 8'h30 + 8'(i));
      read_byte("simul_tail", 8'h55);
      rdd();
      step(1, 8'h66, 8'h00, 0, 0, 0, 0);
      chk("simul_empty_cnt", count, 1);
      read_byte("simul_empty_byte", 8'h66);

      // deselected and empty reads
      selw(8'h00);
      push(8'h77);
      read_byte("desel_data", 8'h00);
      rds();
      chk("desel_status", last_bus, 8'h00);
      idle();
      chk("desel_cnt", count, 1);
      selw(DEV);
      read_byte("resel_data", 8'h77);
      read_byte("empty_read", 8'h00);
      push(8'h88);
      read_byte("after_empty", 8'h88);

      // async reset with three entries and a read in progress
      for (int i = 0; i < 3; i++) push(8'h90 + 8'(i));
      rdd();
      do_reset();

      // randomized traffic
      r_e = 0; r_da = 0; r_io = 0;
      for (int i = 0; i < 3000; i++) begin
         r_ks = ($urandom_range(0, 99) < 35);
         r_kd = 8'($urandom);
         r_s  = ($urandom_range(0, 19) == 0);
         r_bi = ($urandom_range(0, 3) == 0) ? 8'($urandom) : DEV;
         if ($urandom_range(0, 2) == 0) begin
            r_e  = $urandom_range(0, 1);
            r_da = $urandom_range(0, 1);
            r_io = ($urandom_range(0, 3) == 0);
         end
         if (r_s) begin
            r_da = 1; r_io = 1;
         end
         step(r_ks, r_kd, r_bi, r_s, r_e, r_da, r_io);
         if (i == 1500) begin
            do_reset();
            selw(DEV);
            r_e = 0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
